// File: rtl/arm_ctrl_unit.sv
// arm_ctrl_unit: multicycle ARM control FSM with NZCV flag register and conditional execution.
// Optional feature macro: ARMCTRL_CMP_EN (CMP support; undefined leaves cmd 1010 unsupported).
module arm_ctrl_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUControl,
    output logic [3:0]  Flags
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
    } state_t;
    state_t state_q, state_d, st;
    logic [3:0] flags_q, flags_d;
    logic cond_ok_q, cond_ok_d;
    logic [3:0] cond, cmd, rd;
    logic [1:0] op, alu_dec;
    logic [5:0] funct;
    logic is_add, is_sub, is_and, is_orr, is_cmp, wr_dp, cond_eval, rd15, n, z, c, v;
    logic unused;
    assign cond   = instr[31:28];
    assign op     = instr[27:26];
    assign funct  = instr[25:20];
    assign rd     = instr[15:12];
    assign cmd    = funct[4:1];
    assign rd15   = rd == 4'hf;
    assign {n, z, c, v} = flags_q;
    assign unused = ^{instr[19:16], instr[11:0]};
    assign Flags  = flags_q;
    assign ImmSrc = op;
    assign RegSrc = {op == 2'b01, op == 2'b10};
    // Data-processing command decode; CMP only exists when the feature macro is set.
    always_comb begin
        is_add  = cmd == 4'b0100;
        is_sub  = cmd == 4'b0010;
        is_and  = cmd == 4'b0000;
        is_orr  = cmd == 4'b1100;
`ifdef ARMCTRL_CMP_EN
        is_cmp  = cmd == 4'b1010;
`else
        is_cmp  = 1'b0;
`endif
        wr_dp   = is_add | is_sub | is_and | is_orr;
        alu_dec = (is_sub | is_cmp) ? 2'b01 : is_and ? 2'b10 : is_orr ? 2'b11 : 2'b00;
    end
    // Condition-code evaluation against the current flag register.
    always_comb begin
        case (cond)
            4'b0000: cond_eval = z;
            4'b0001: cond_eval = !z;
            4'b0010: cond_eval = c;
            4'b0011: cond_eval = !c;
            4'b0100: cond_eval = n;
            4'b0101: cond_eval = !n;
            4'b0110: cond_eval = v;
            4'b0111: cond_eval = !v;
            4'b1000: cond_eval = c & !z;
            4'b1001: cond_eval = !c | z;
            4'b1010: cond_eval = n == v;
            4'b1011: cond_eval = n != v;
            4'b1100: cond_eval = !z & (n == v);
            4'b1101: cond_eval = z | (n != v);
            4'b1110: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    end
    // Next state, latched condition and flag updates; reset restarts at FETCH with flags cleared.
    always_comb begin
        case (state_q)
            FETCH:        state_d = DECODE;
            DECODE:       state_d = op == 2'b01 ? MEMADR : op == 2'b00 ? (funct[5] ? EXECI : EXECR) :
                                    op == 2'b10 ? BRANCH : FETCH;
            MEMADR:       state_d = funct[0] ? MEMRD : MEMWR;
            MEMRD:        state_d = MEMWB;
            EXECR, EXECI: state_d = ALUWB;
            default:      state_d = FETCH;
        endcase
        cond_ok_d = state_q == DECODE ? cond_eval : cond_ok_q;
        flags_d   = flags_q;
        if ((state_q == EXECR || state_q == EXECI) && cond_ok_q) begin
            if (((is_add | is_sub) & funct[0]) | is_cmp)
                flags_d = ALUFlags;
            else if ((is_and | is_orr) & funct[0])
                flags_d = {ALUFlags[3:2], flags_q[1:0]};
        end
        if (rst) begin
            state_d   = FETCH;
            cond_ok_d = 1'b0;
            flags_d   = 4'b0000;
        end
    end
    // Moore outputs; under reset selects show FETCH values and all enables are suppressed.
    always_comb begin
        st         = rst ? FETCH : state_q;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        case (st)
            FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                PCWrite   = cond_ok_q & rd15;
                RegWrite  = cond_ok_q & !rd15;
            end
            MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_ok_q;
            end
            EXECR: ALUControl = alu_dec;
            EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec;
            end
            ALUWB: begin
                PCWrite  = cond_ok_q & rd15;
                RegWrite = cond_ok_q & !rd15 & wr_dp;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_ok_q;
            end
            default: ;
        endcase
        if (rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end
    // State, condition and flag registers.
    always_ff @(posedge clk) begin
        state_q   <= state_d;
        cond_ok_q <= cond_ok_d;
        flags_q   <= flags_d;
    end
endmodule

// File: tb/tb_arm_ctrl_unit.sv
// tb_arm_ctrl_unit: scoreboard bench with an instruction-level reference model.
module tb_arm_ctrl_unit;
    logic clk = 1'b0, rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic [3:0] alu_flags = 4'h0;
    logic PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
    logic [3:0] Flags;
    int checks = 0, errors = 0;
    typedef struct { logic [19:0] v; string tag; } exp_t;
    exp_t q[$];
    exp_t e;
    logic [3:0] m_flags = 4'h0;

    arm_ctrl_unit dut (
        .clk(clk), .rst(rst), .instr(instr), .ALUFlags(alu_flags),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .Flags(Flags)
    );

    always #5 clk = ~clk;

    wire [19:0] act = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, ALUSrcB,
                       ResultSrc, ImmSrc, RegSrc, ALUControl, Flags};

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s instr=%h: got %h expected %h", e.tag, instr, act, e.v);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input bit pcw, input bit irw, input bit mw, input bit rw,
                        input bit adr, input bit sa, input bit [1:0] sb, input bit [1:0] rs,
                        input bit [1:0] alu);
        exp_t x;
        x.tag = tag;
        x.v = {pcw, irw, mw, rw, adr, sa, sb, rs, instr[27:26],
               instr[27:26] == 2'b01, instr[27:26] == 2'b10, alu, m_flags};
        q.push_back(x);
    endtask

    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
        bit n = f[3], z = f[2], cy = f[1], v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && n == v;
            4'hD: return z || n != v;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic issue(input logic [31:0] i, input logic [3:0] af);
        bit ok, rd15, s, arith, logical, writes;
        bit [1:0] alu;
        int len;
        instr = i;
        alu_flags = af;
        ok = cond_pass(i[31:28], m_flags);
        rd15 = i[15:12] == 4'hf;
        s = i[20];
        push("fetch", 1, 1, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00);
        push("decode", 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00);
        len = 2;
        if (i[27:26] == 2'b10) begin
            push("branch", ok, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00);
            len = 3;
        end else if (i[27:26] == 2'b01) begin
            push("memadr", 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
            if (i[20]) begin
                push("memrd", 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
                push("memwb", ok && rd15, 0, 0, ok && !rd15, 0, 0, 2'b00, 2'b01, 2'b00);
                len = 5;
            end else begin
                push("memwr", 0, 0, ok, 0, 1, 0, 2'b00, 2'b00, 2'b00);
                len = 4;
            end
        end else if (i[27:26] == 2'b00) begin
            arith = 0; logical = 0; writes = 1; alu = 2'b00;
            case (i[24:21])
                4'b0100: begin alu = 2'b00; arith = s; end
                4'b0010: begin alu = 2'b01; arith = s; end
                4'b0000: begin alu = 2'b10; logical = s; end
                4'b1100: begin alu = 2'b11; logical = s; end
`ifdef ARMCTRL_CMP_EN
                4'b1010: begin alu = 2'b01; arith = 1; writes = 0; end
`endif
                default: writes = 0;
            endcase
            push("exec", 0, 0, 0, 0, 0, 0, i[25] ? 2'b01 : 2'b00, 2'b00, alu);
            if (ok && arith) m_flags = af;
            else if (ok && logical) m_flags[3:2] = af[3:2];
            push("aluwb", ok && rd15, 0, 0, ok && !rd15 && writes, 0, 0, 2'b00, 2'b00, 2'b00);
            len = 4;
        end
        repeat (len) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] ri;
        instr = $urandom;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_enables", {PCWrite, IRWrite, MemWrite, RegWrite}, 4'b0000);
        chk("reset_flags", Flags, 4'b0000);
        chk("reset_selects", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}, 8'b0_1_10_10_00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(32'hE0821003, 4'hA);
        issue(32'hE2511001, 4'b0100);
        issue(32'h0A000002, 4'h0);
        issue(32'hE2511001, 4'b0000);
        issue(32'h0A000002, 4'h0);
        issue(32'hE5910004, 4'h3);
        issue(32'hE5810004, 4'h3);
        issue(32'hE1510002, 4'b0110);
        issue(32'hE0921003, 4'b1111);
        for (int k = 0; k < 300; k++) begin
            ri = $urandom;
            if ($urandom_range(3) == 0) ri[15:12] = 4'hf;
            if ($urandom_range(3) == 0) ri[31:28] = 4'hE;
            issue(ri, 4'($urandom));
        end
        issue(32'hE0921003, 4'b1111);
        instr = 32'hE5910004;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_memrd_enables", {PCWrite, IRWrite, MemWrite, RegWrite}, 4'b0000);
        chk("rst_memrd_selects", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}, 8'b0_1_10_10_00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_fetch_flags", Flags, 4'b0000);
        chk("rst_fetch_enables", {PCWrite, IRWrite, MemWrite, RegWrite}, 4'b1100);
        @(negedge clk);
        chk("rst_decode", {PCWrite, IRWrite, RegWrite, ALUSrcA, ALUSrcB}, 6'b000110);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/arm_ctrl_unit.md
# arm_ctrl_unit

Multicycle control unit for the ARMController datapath. It decodes the held instruction word, sequences a Moore state machine through fetch, decode, execute, memory and writeback, and drives the datapath mux selects and write enables. It issues the 2-bit `ALUControl` code to the datapath ALU and keeps the NZCV condition-flag register from the ALU's flag outputs. Conditional execution is evaluated once per instruction.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `instr` input 32: instruction register contents, stable from the cycle after FETCH.
  - Fields: Cond=[31:28], Op=[27:26], Funct=[25:20], Rd=[15:12].
- `ALUFlags` input 4: NZCV from the datapath ALU for the current operation.
- `PCWrite` output 1: PC write enable.
- `IRWrite` output 1: IR write enable.
- `MemWrite` output 1: data memory write enable.
- `RegWrite` output 1: register file write enable.
- `AdrSrc` output 1: 0 = PC, 1 = ALU result.
- `ALUSrcA` output 1: 0 = register A, 1 = PC.
- `ALUSrcB` output 2: 00 = register B, 01 = extended immediate, 10 = constant 4.
- `ResultSrc` output 2: 00 = ALUOut, 01 = memory data, 10 = ALU result.
- `ImmSrc` output 2: equal to Op.
- `RegSrc` output 2: [0] = (Op==10), [1] = (Op==01).
- `ALUControl` output 2: 00 ADD, 01 SUB, 10 AND, 11 OR.
- `Flags` output 4: NZCV flag register.

## Operation
- **States:** FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- **Transitions:**
  - FETCH → DECODE.
  - DECODE: Op=01 → MEMADR; Op=00 and Funct[5]=0 → EXECR; Op=00 and Funct[5]=1 → EXECI; Op=10 → BRANCH; Op=11 → FETCH.
  - MEMADR: Funct[0]=1 → MEMRD, else → MEMWR.
  - MEMRD → MEMWB → FETCH. MEMWR → FETCH.
  - EXECR / EXECI → ALUWB → FETCH. BRANCH → FETCH.
- **Outputs per state** (unlisted enables 0, unlisted selects 0):
  - FETCH: IRWrite=1, PCWrite=1 (unconditional), ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=00.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=00.
  - MEMADR: ALUSrcB=01, ALUControl=00.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, write.
  - MEMWR: AdrSrc=1, MemWrite=cond_ok.
  - EXECR: ALUSrcB=00, ALUControl decoded.
  - EXECI: ALUSrcB=01, ALUControl decoded.
  - ALUWB: ResultSrc=00, write.
  - BRANCH: ALUSrcB=01, ResultSrc=10, ALUControl=00, PCWrite=cond_ok.
- **"write" in MEMWB/ALUWB:**
  - Rd==15: PCWrite=cond_ok, RegWrite=0.
  - Otherwise: RegWrite=cond_ok.
  - RegWrite is also 0 for CMP and for unsupported commands.
- **ALU decode** (cmd = Funct[4:1]): 0100 → 00, 0010 → 01, 0000 → 10, 1100 → 11, 1010 (CMP) → 01.
  - Any other cmd is unsupported: ALUControl=00, no register write, no flag write.
- **Flag write:**
  - ADD/SUB with S=1, and CMP: update NZCV.
  - AND/ORR with S=1: update NZ only; CV hold.
  - Flags are captured from ALUFlags at the end of EXECR/EXECI, only if cond_ok.
- **Condition:** cond_ok is registered at the end of DECODE from Cond and the current Flags. It holds for the rest of the instruction.
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL 1; 1111 → 0.

## Timing
- **Reset:** while `rst` is high at a clock edge: state ← FETCH, Flags ← 0000, cond_ok ← 0.
  - PCWrite, IRWrite, MemWrite and RegWrite are forced 0 for every cycle in which `rst` is high.
  - Selects take their FETCH values.
- **Reset mid-instruction:** any state → FETCH on the next edge. Pending writes are dropped and flags are cleared.
- **Cycles per instruction:** LDR 5, STR 4, data-processing 4, B 3, Op=11 2.
  - A failed condition does not shorten the path; it only suppresses the gated writes.
- **Output timing:** outputs are combinational from state plus instr/cond_ok, valid within the same cycle.
- **Flag visibility:** new Flags are visible in ALUWB. They first affect cond_ok in the next instruction's DECODE.

## Configuration
- `ARMCTRL_CMP_EN` defined: CMP (cmd 1010) decodes to ALUControl=01, updates NZCV if cond_ok, and has RegWrite=0 in ALUWB.
- `ARMCTRL_CMP_EN` undefined: cmd 1010 is unsupported — ALUControl=00, no flag write, no register write. The state path is unchanged.

## Test plan
- Reset, then instr=0xE0821003 (ADD R1,R2,R3):
  - States FETCH, DECODE, EXECR, ALUWB, FETCH.
  - ALUControl=00 in EXECR; RegWrite=1 only in ALUWB.
- instr=0xE2511001 (SUBS imm) with ALUFlags=0100:
  - EXECI has ALUControl=01, ALUSrcB=01.
  - Flags=0100 from ALUWB onward.
- Then instr=0x0A000002 (BEQ):
  - PCWrite=1 in BRANCH.
  - Repeat with Flags=0000: PCWrite=0 in BRANCH; path is still 3 cycles.
- instr=0xE5910004 (LDR):
  - 5 cycles; AdrSrc=1 in MEMRD; MEMWB has ResultSrc=01, RegWrite=1.
- instr=0xE5810004 (STR):
  - 4 cycles; MemWrite=1 only in MEMWR.
- CMP and reset:
  - instr=0xE1510002 (CMP) with ALUFlags=0110 and macro defined: ALUControl=01, Flags=0110, RegWrite=0.
  - Same CMP without macro: Flags unchanged.
  - Assert rst in MEMRD: next state FETCH, Flags=0000, no RegWrite.
